// File: rtl/sram_sp_fifo_ctrl.sv
// ============================================================================
// Module   : sram_sp_fifo_ctrl
// Desc     : Valid/ready FIFO built on one single-port SRAM plus a small
//            prefetch buffer; optional macro SRAM_SP_FIFO_LVL_EN adds lvl_o.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sram_sp_fifo_ctrl #(
  parameter int SIZE     = -1,
  parameter int DATA_WD  = -1,
  parameter int SRAM_LAT = -1,
  // Unset parameters are clamped so the block still elaborates stand-alone.
  localparam int c_SZ    = (SIZE >= 2) ? SIZE : 2,
  localparam int c_DW    = (DATA_WD >= 1) ? DATA_WD : 1,
  localparam int c_LAT   = (SRAM_LAT == 2) ? 2 : 1,
  localparam int SIZE_WD = $clog2(c_SZ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_val_i,
  input  logic [c_DW-1:0]    in_dat_i,
  output logic               in_rdy_o,
  output logic               out_val_o,
  output logic [c_DW-1:0]    out_dat_o,
  input  logic               out_rdy_i,
  output logic [SIZE_WD-1:0] sram_adr_o,
  output logic               sram_wr_val_o,
  output logic [c_DW-1:0]    sram_wr_dat_o,
  output logic               sram_rd_val_o,
  input  logic               sram_rd_val_i,
  input  logic [c_DW-1:0]    sram_rd_dat_i
`ifdef SRAM_SP_FIFO_LVL_EN
  ,
  output logic [SIZE_WD+1:0] lvl_o
`endif
);

  localparam int c_BUF = c_LAT + 2;
  localparam int c_CW  = $clog2(c_SZ + 1);
  localparam int c_OW  = $clog2(c_BUF + 1);
  localparam int c_IW  = $clog2(c_LAT + 1);
  localparam int c_BPW = $clog2(c_BUF);

  localparam logic [c_CW-1:0]    c_CNT_FULL = c_CW'(c_SZ);
  localparam logic [SIZE_WD-1:0] c_PTR_LAST = SIZE_WD'(c_SZ - 1);
  localparam logic [c_BPW-1:0]   c_BUF_LAST = c_BPW'(c_BUF - 1);
  localparam logic [c_OW:0]      c_BUF_V    = (c_OW + 1)'(c_BUF);

  logic [SIZE_WD-1:0] r_wr_ptr;
  logic [SIZE_WD-1:0] r_rd_ptr;
  logic [SIZE_WD-1:0] r_adr;
  logic [c_CW-1:0]    r_cnt;
  logic [c_OW-1:0]    r_occ;
  logic [c_IW-1:0]    r_infl;
  logic               r_last_rd;
  logic [c_BPW-1:0]   r_head;
  logic [c_BPW-1:0]   r_tail;
  logic [c_DW-1:0]    r_last_dat;
  logic [c_DW-1:0]    r_buf [c_BUF];

  logic [c_OW:0]      w_credit;
  logic               w_rd_req;
  logic               w_wr_req;
  logic               w_rd_gnt;
  logic               w_wr_gnt;
  logic               w_pop;
  logic [c_CW-1:0]    w_cnt_nxt;
  logic [c_OW-1:0]    w_occ_nxt;
  logic [c_IW-1:0]    w_infl_nxt;

  // Credit counts only registered state: a pop frees its slot one cycle later.
  assign w_credit = (c_OW + 1)'(r_occ) + (c_OW + 1)'(r_infl);
  assign w_rd_req = (r_cnt != '0) && (w_credit < c_BUF_V);
  assign w_wr_req = in_val_i && (r_cnt != c_CNT_FULL);

  // Tie-break alternates: a write wins only right after a read grant.
  assign w_rd_gnt = w_rd_req && (!w_wr_req || !r_last_rd);
  assign w_wr_gnt = w_wr_req && !w_rd_gnt;

  assign in_rdy_o      = (r_cnt != c_CNT_FULL) && !w_rd_gnt;
  assign sram_wr_val_o = w_wr_gnt;
  assign sram_rd_val_o = w_rd_gnt;
  assign sram_wr_dat_o = in_dat_i;
  assign sram_adr_o    = w_wr_gnt ? r_wr_ptr : (w_rd_gnt ? r_rd_ptr : r_adr);

  assign out_val_o = (r_occ != '0);
  assign w_pop     = out_val_o && out_rdy_i;
  assign out_dat_o = out_val_o ? r_buf[r_head] : r_last_dat;

  always_comb begin
    w_cnt_nxt  = r_cnt + c_CW'(w_wr_gnt) - c_CW'(w_rd_gnt);
    w_infl_nxt = r_infl + c_IW'(w_rd_gnt) - c_IW'(sram_rd_val_i);
    w_occ_nxt  = r_occ + c_OW'(sram_rd_val_i) - c_OW'(w_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_adr      <= '0;
      r_cnt      <= '0;
      r_occ      <= '0;
      r_infl     <= '0;
      r_last_rd  <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_last_dat <= '0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_occ  <= w_occ_nxt;
      r_infl <= w_infl_nxt;
      r_adr  <= sram_adr_o;
      if (w_wr_gnt) begin
        r_wr_ptr  <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + SIZE_WD'(1);
        r_last_rd <= 1'b0;
      end
      if (w_rd_gnt) begin
        r_rd_ptr  <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + SIZE_WD'(1);
        r_last_rd <= 1'b1;
      end
      if (sram_rd_val_i) begin
        r_tail <= (r_tail == c_BUF_LAST) ? '0 : r_tail + c_BPW'(1);
      end
      if (w_pop) begin
        r_head     <= (r_head == c_BUF_LAST) ? '0 : r_head + c_BPW'(1);
        r_last_dat <= r_buf[r_head];
      end
    end
  end

  // Buffer storage needs no reset; visibility is governed by r_occ.
  always_ff @(posedge clk) begin
    if (sram_rd_val_i && !rst) begin
      r_buf[r_tail] <= sram_rd_dat_i;
    end
  end

`ifdef SRAM_SP_FIFO_LVL_EN
  logic [SIZE_WD+1:0] r_lvl;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvl <= '0;
    end else begin
      r_lvl <= (SIZE_WD + 2)'(w_cnt_nxt) + (SIZE_WD + 2)'(w_infl_nxt)
             + (SIZE_WD + 2)'(w_occ_nxt);
    end
  end

  assign lvl_o = r_lvl;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sram_sp_fifo_ctrl.sv
// ============================================================================
// Module   : tb_sram_sp_fifo_ctrl
// Desc     : Directed self-checking bench for sram_sp_fifo_ctrl with a
//            behavioural single-port SRAM (latency 1).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sram_sp_fifo_ctrl;

  localparam int SIZE     = 8;
  localparam int DATA_WD  = 16;
  localparam int SRAM_LAT = 1;
  localparam int AW       = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_val_i = 1'b0;
  logic [DATA_WD-1:0] in_dat_i = '0;
  logic               in_rdy_o;
  logic               out_val_o;
  logic [DATA_WD-1:0] out_dat_o;
  logic               out_rdy_i = 1'b0;
  logic [AW-1:0]      sram_adr_o;
  logic               sram_wr_val_o;
  logic [DATA_WD-1:0] sram_wr_dat_o;
  logic               sram_rd_val_o;
  logic               sram_rd_val_i;
  logic [DATA_WD-1:0] sram_rd_dat_i;
  logic [AW+1:0]      lvl_o;

  always #5 clk = ~clk;

  sram_sp_fifo_ctrl #(
    .SIZE     (SIZE),
    .DATA_WD  (DATA_WD),
    .SRAM_LAT (SRAM_LAT)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .in_val_i      (in_val_i),
    .in_dat_i      (in_dat_i),
    .in_rdy_o      (in_rdy_o),
    .out_val_o     (out_val_o),
    .out_dat_o     (out_dat_o),
    .out_rdy_i     (out_rdy_i),
    .sram_adr_o    (sram_adr_o),
    .sram_wr_val_o (sram_wr_val_o),
    .sram_wr_dat_o (sram_wr_dat_o),
    .sram_rd_val_o (sram_rd_val_o),
    .sram_rd_val_i (sram_rd_val_i),
    .sram_rd_dat_i (sram_rd_dat_i)
`ifdef SRAM_SP_FIFO_LVL_EN
    ,
    .lvl_o         (lvl_o)
`endif
  );

`ifndef SRAM_SP_FIFO_LVL_EN
  assign lvl_o = '0;
`endif

  // Behavioural single-port SRAM, one-cycle read latency, read pipe reset.
  logic [DATA_WD-1:0] mem [SIZE];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_rd_val_i <= 1'b0;
      sram_rd_dat_i <= '0;
    end else begin
      sram_rd_val_i <= sram_rd_val_o;
      if (sram_rd_val_o) sram_rd_dat_i <= mem[sram_adr_o];
    end
  end

  always_ff @(posedge clk) begin
    if (sram_wr_val_o && !rst) mem[sram_adr_o] <= sram_wr_dat_o;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and address/arbitration monitor, sampled mid-cycle.
  logic [DATA_WD-1:0] sb_q[$];
  int exp_wp = 0, exp_rp = 0, wrap_w = 0, wrap_r = 0;
  int n_conf = 0, alt_err = 0, n_gnt = 0, last_g = -1;
  bit alt_on = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
      exp_wp = 0;
      exp_rp = 0;
    end else begin
      if (sram_wr_val_o && sram_rd_val_o) n_conf++;
      if (sram_wr_val_o) begin
        chk("wr_adr", 32'(sram_adr_o), 32'(exp_wp));
        if (exp_wp == SIZE - 1) begin exp_wp = 0; wrap_w++; end
        else exp_wp++;
      end
      if (sram_rd_val_o) begin
        chk("rd_adr", 32'(sram_adr_o), 32'(exp_rp));
        if (exp_rp == SIZE - 1) begin exp_rp = 0; wrap_r++; end
        else exp_rp++;
      end
      if (in_val_i && in_rdy_o) sb_q.push_back(in_dat_i);
      if (out_val_o && out_rdy_i) begin
        if (sb_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
        else chk("pop_dat", 32'(out_dat_o), 32'(sb_q.pop_front()));
      end
      if (alt_on && (sram_wr_val_o || sram_rd_val_o)) begin
        if ((sram_wr_val_o ? 0 : 1) == last_g) alt_err++;
        last_g = sram_wr_val_o ? 0 : 1;
        n_gnt++;
      end
    end
  end

  task automatic drain(input string tag);
    int c;
    in_val_i  = 1'b0;
    out_rdy_i = 1'b1;
    c = 0;
    while ((sb_q.size() != 0 || out_val_o) && c < 100) begin
      tick();
      c++;
    end
    chk(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int acc;

    // Reset state
    tick(); tick();
    chk("rst_in_rdy", 32'(in_rdy_o), 32'd1);
    chk("rst_out_val", 32'(out_val_o), 32'd0);
    chk("rst_out_dat", 32'(out_dat_o), 32'd0);
    chk("rst_wr_val", 32'(sram_wr_val_o), 32'd0);
    chk("rst_rd_val", 32'(sram_rd_val_o), 32'd0);
    chk("rst_adr", 32'(sram_adr_o), 32'd0);
    chk("rst_lvl", 32'(lvl_o), 32'd0);
    rst = 1'b0;

    // Single push: write at cycle 0, read at 1, visible at 3
    tick();
    in_val_i = 1'b1; in_dat_i = 16'h1234; out_rdy_i = 1'b1;
    #1 chk("t1_wr", 32'(sram_wr_val_o), 32'd1);
    tick(); in_val_i = 1'b0;
    #1 chk("t1_rd", 32'(sram_rd_val_o), 32'd1);
`ifdef SRAM_SP_FIFO_LVL_EN
    chk("t1_lvl1", 32'(lvl_o), 32'd1);
`endif
    tick(); #1 chk("t1_val_c2", 32'(out_val_o), 32'd0);
    tick(); #1 chk("t1_val_c3", 32'(out_val_o), 32'd1);
    chk("t1_dat_c3", 32'(out_dat_o), 32'h1234);
    tick(); #1 chk("t1_val_c4", 32'(out_val_o), 32'd0);
    chk("t1_hold_c4", 32'(out_dat_o), 32'h1234);
`ifdef SRAM_SP_FIFO_LVL_EN
    chk("t1_lvl0", 32'(lvl_o), 32'd0);
`endif

    // Fill to capacity with the consumer stalled
    tick();
    out_rdy_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 100 && acc < 11; c++) begin
      in_val_i = 1'b1; in_dat_i = 16'(acc);
      #1 if (in_rdy_o) acc++;
      tick();
    end
    chk("fill_acc", 32'(acc), 32'd11);
    in_dat_i = 16'd11;
    tick(); tick();
    #1 chk("full_rdy", 32'(in_rdy_o), 32'd0);
    chk("full_head", 32'(out_dat_o), 32'd0);
`ifdef SRAM_SP_FIFO_LVL_EN
    chk("full_lvl", 32'(lvl_o), 32'd11);
`endif
    tick();
    in_val_i = 1'b0; out_rdy_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #1 chk("drain_val", 32'(out_val_o), 32'd1);
      chk("drain_dat", 32'(out_dat_o), 32'(i));
      tick();
    end
    #1 chk("drain_done", 32'(out_val_o), 32'd0);

    // Continuous push and pop: strict W/R alternation
    tick();
    acc = 0; last_g = -1; n_gnt = 0; alt_err = 0; alt_on = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_val_i = 1'b1; in_dat_i = 16'h0100 + 16'(acc); out_rdy_i = 1'b1;
      #1 if (in_rdy_o) acc++;
      tick();
    end
    alt_on = 1'b0; in_val_i = 1'b0;
    chk("alt_err", 32'(alt_err), 32'd0);
    chk("alt_gnts", 32'(n_gnt), 32'd40);
    chk("alt_push", 32'(acc), 32'd20);
    drain("alt_drain");

    // 20 items through the pointer wrap with a random consumer
    acc = 0;
    for (int c = 0; c < 400 && acc < 20; c++) begin
      in_val_i = 1'b1; in_dat_i = 16'h2000 + 16'(acc);
      out_rdy_i = 1'($urandom_range(0, 1));
      #1 if (in_rdy_o) acc++;
      tick();
    end
    chk("wrap_acc", 32'(acc), 32'd20);
    drain("wrap_drain");
    chk("wrap_w", 32'(wrap_w), 32'd6);
    chk("wrap_r", 32'(wrap_r), 32'd6);

    // Reset with entries stored and a read in flight
    out_rdy_i = 1'b0;
    acc = 0;
    for (int c = 0; c < 100 && acc < 6; c++) begin
      in_val_i = 1'b1; in_dat_i = 16'h3000 + 16'(acc);
      #1 if (in_rdy_o) acc++;
      tick();
    end
    in_val_i = 1'b0; out_rdy_i = 1'b1;
    #1 chk("r5_head", 32'(out_dat_o), 32'h3000);
    tick(); out_rdy_i = 1'b0;
    #1 chk("r5_rd_issue", 32'(sram_rd_val_o), 32'd1);
    tick();
    rst = 1'b1;
    #1 chk("r5_in_rdy", 32'(in_rdy_o), 32'd1);
    chk("r5_out_val", 32'(out_val_o), 32'd0);
    chk("r5_out_dat", 32'(out_dat_o), 32'd0);
    chk("r5_wr_val", 32'(sram_wr_val_o), 32'd0);
    chk("r5_rd_val", 32'(sram_rd_val_o), 32'd0);
    chk("r5_adr", 32'(sram_adr_o), 32'd0);
    chk("r5_lvl", 32'(lvl_o), 32'd0);
    tick(); rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1 chk("r5_quiet", 32'(out_val_o), 32'd0);
      tick();
    end

    // Fresh push after reset, popped the cycle it becomes visible
    in_val_i = 1'b1; in_dat_i = 16'hBEEF; out_rdy_i = 1'b1;
    #1 chk("bf_wr_adr", 32'(sram_adr_o), 32'd0);
    tick(); in_val_i = 1'b0;
    #1 chk("bf_val_c1", 32'(out_val_o), 32'd0);
    tick(); #1 chk("bf_val_c2", 32'(out_val_o), 32'd0);
    tick(); #1 chk("bf_val_c3", 32'(out_val_o), 32'd1);
    chk("bf_dat_c3", 32'(out_dat_o), 32'hBEEF);
    tick(); #1 chk("bf_val_c4", 32'(out_val_o), 32'd0);
    chk("bf_hold_c4", 32'(out_dat_o), 32'hBEEF);
    tick(); #1 chk("bf_hold_c5", 32'(out_dat_o), 32'hBEEF);

    chk("no_rw_conflict", 32'(n_conf), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/sram_sp_fifo_ctrl.md
# sram_sp_fifo_ctrl

FIFO controller that turns one single-port SRAM instance (sram_sp_behave_sim in simulation) into a valid/ready streaming FIFO. It sits directly upstream of the SRAM: it drives the shared address, write and read strobes, and consumes the SRAM read return. One access (read or write) is arbitrated per cycle, and a small prefetch buffer hides the SRAM read latency from the consumer.

## Interface
Parameters:
- SIZE, -1 (must be set), SRAM depth in entries; any value ≥ 2; SIZE_WD = FUNC_LOG2(SIZE).
- DATA_WD, -1 (must be set), data width; must match the SRAM.
- SRAM_LAT, -1 (must be set), SRAM read latency: 1 (SRAM KNOB_REGOUT=0) or 2 (KNOB_REGOUT=1).
- Derived BUF_DEPTH = SRAM_LAT+2, prefetch buffer entries.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-high reset; the integrator drives the SRAM rstn with !rst.
- in_val_i  in  1  push request.
- in_dat_i  in  DATA_WD  push data.
- in_rdy_o  out  1  push accepted when in_val_i && in_rdy_o.
- out_val_o  out  1  pop data valid.
- out_dat_o  out  DATA_WD  pop data; head of prefetch buffer.
- out_rdy_i  in  1  consumer ready; pop when out_val_o && out_rdy_i.
- sram_adr_o  out  SIZE_WD  shared SRAM address.
- sram_wr_val_o  out  1  SRAM write strobe.
- sram_wr_dat_o  out  DATA_WD  SRAM write data (= in_dat_i).
- sram_rd_val_o  out  1  SRAM read strobe.
- sram_rd_val_i  in  1  SRAM read return valid.
- sram_rd_dat_i  in  DATA_WD  SRAM read return data.
- lvl_o  out  SIZE_WD+2  total occupancy (only with SRAM_SP_FIFO_LVL_EN).

## Operation
- State: wr_ptr, rd_ptr (0..SIZE-1, wrap to 0 after SIZE-1, explicit compare, no power-of-two assumption); sram_cnt (0..SIZE); buf_occ (0..BUF_DEPTH); inflight (0..SRAM_LAT); last_rd (1 bit).
- credit = buf_occ + inflight (registered values only; a pop this cycle frees credit next cycle).
- rd_req = (sram_cnt != 0) && (credit < BUF_DEPTH). wr_req = in_val_i && (sram_cnt != SIZE).
- Arbiter: if both requested, grant write when last_rd==1, else read; a single request is granted alone. last_rd <= 1 on a read grant and 0 on a write grant; it holds when idle.
- in_rdy_o = (sram_cnt != SIZE) && !rd_grant; combinational, and depends on in_val_i only through the arbiter tie-break.
- Write grant: sram_wr_val_o=1, sram_adr_o=wr_ptr; wr_ptr advances, sram_cnt+1.
- Read grant: sram_rd_val_o=1, sram_adr_o=rd_ptr; rd_ptr advances, sram_cnt-1, inflight+1.
- Neither granted: the strobes are 0 and sram_adr_o holds its last value.
- The SRAM never sees read and write in the same cycle.
- sram_rd_val_i pushes sram_rd_dat_i into the buffer tail and decrements inflight. Overflow is impossible by credit.
- Pop removes the buffer head. Simultaneous return and pop in one cycle is legal, and buf_occ is unchanged.
- Data order is strictly FIFO. Capacity is SIZE + BUF_DEPTH entries.

## Timing
- Reset values: in_rdy_o=1 (combinational from reset state), out_val_o=0, out_dat_o=0, sram_wr_val_o=0, sram_rd_val_o=0, sram_adr_o=0, lvl_o=0; all pointers and counters 0, last_rd=0.
- Latency: a push accepted in cycle t is written at the end of t, read issued at t+1 (if granted), returned at t+1+SRAM_LAT, and out_val_o=1 at t+2+SRAM_LAT.
- Throughput: with continuous push and pop, write and read alternate, giving 1 entry per 2 cycles. With push only, 1/cycle until full. With drain only, 1/cycle sustained (BUF_DEPTH covers the round trip).
- Full (sram_cnt==SIZE): in_rdy_o=0 and data is held off without loss. Empty: out_val_o=0, and out_dat_o keeps the last popped value.
- Reset mid-operation: all state clears asynchronously. sram_rd_val_i arriving while rst=1 is ignored. Returns from reads issued before reset cannot arrive after release, because the SRAM read pipeline is also reset.

## Configuration
- SRAM_SP_FIFO_LVL_EN defined: port lvl_o exists and is registered as sram_cnt + inflight + buf_occ, updated every cycle. It reads 0 after reset and SIZE+BUF_DEPTH when completely full.
- SRAM_SP_FIFO_LVL_EN undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
Bench setup: SIZE=8, DATA_WD=16, SRAM_LAT=1, BUF_DEPTH=3.
- Single push 0x1234 at cycle 0, out_rdy_i=1 → out_val_o=1 with 0x1234 at cycle 3 for exactly one cycle; lvl_o goes 1 → 0.
- Push 0..10 with out_rdy_i=0 → 11 accepted, then in_rdy_o=0 (sram_cnt=8, buf_occ=3) and lvl_o=11. Raise out_rdy_i → 0..10 pop in order, one per cycle sustained.
- Continuous push and pop for 40 cycles → grants alternate W/R, no data loss or reorder, and sram_rd_val_o && sram_wr_val_o is never 1 together.
- Push 20 items through the wrap (SIZE=8) with random out_rdy_i → output matches input order; wr_ptr and rd_ptr wrap 7→0.
- Assert rst for 1 cycle while 5 entries are stored and a read is in flight → all outputs are at reset values, with no out_val_o after release. A new push 0xBEEF then emerges 3 cycles later.
- Drain to empty, then push one item and pop in the same cycle it becomes visible → out_val_o drops the next cycle; out_dat_o holds 0xBEEF.
